// File: rtl/inv_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : inv_share_arbiter
// Purpose  : Round-robin arbiter and sequencer that shares one W-bit inverter
//            datapath among NREQ requesters. It grants one requester, holds
//            its operand on the inverter input for SETTLE cycles, samples the
//            inverter output and returns it tagged with the requester ID.
// Options  : INV_ARB_CHECK_EN - when defined, compares each sampled inverter
//            output with ~inv_in (4-state) and drives chk_err / err_cnt.
//            When undefined, chk_err and err_cnt are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module inv_share_arbiter #(
   parameter int NREQ   = 4,
   parameter int W      = 4,
   parameter int SETTLE = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*W-1:0]       req_data,
   output logic [NREQ-1:0]         gnt,
   output logic [W-1:0]            inv_in,
   input  logic [W-1:0]            inv_out,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [W-1:0]            rsp_data,
   output logic                    busy,
   output logic                    chk_err,
   output logic [7:0]              err_cnt
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  cur_id_q, cur_id_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [W-1:0]    inv_in_q, inv_in_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [W-1:0]    rsp_data_q, rsp_data_d;
   logic            busy_q, busy_d;

   logic            found;
   logic [IDW-1:0]  sel;
   logic [IDW:0]    idx;

   // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NREQ)) begin
            idx = idx - (IDW+1)'(NREQ);
         end
         if (!found && req[idx[IDW-1:0]]) begin
            found = 1'b1;
            sel   = idx[IDW-1:0];
         end
      end
   end

   // Next-state and registered-output computation for the transaction FSM.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cur_id_d    = cur_id_q;
      cnt_d       = cnt_q;
      gnt_d       = '0;
      inv_in_d    = inv_in_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_d    = NREQ'(1) << sel;
               inv_in_d = req_data[sel*W +: W];
               cur_id_d = sel;
               cnt_d    = CW'(SETTLE - 1);
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               rsp_data_d  = inv_out;
               rsp_id_d    = cur_id_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESP: begin
            // Rotate priority so the just-served requester goes last.
            rr_ptr_d = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + IDW'(1);
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset discards any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         cur_id_q    <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         inv_in_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cur_id_q    <= cur_id_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         inv_in_q    <= inv_in_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt       = gnt_q;
   assign inv_in    = inv_in_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

`ifdef INV_ARB_CHECK_EN
   logic       chk_fire;
   logic       mismatch;
   logic       chk_err_q, chk_err_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   // Case inequality so that X or Z on the inverter output is a mismatch.
   always_comb begin
      chk_fire  = (state_q == S_SETTLE) && (cnt_q == '0);
      mismatch  = (inv_out !== ~inv_in_q);
      chk_err_d = chk_fire && mismatch;
      err_cnt_d = err_cnt_q;
      if (chk_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Check-result registers, aligned with rsp_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_err_q <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         chk_err_q <= chk_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign chk_err = chk_err_q;
   assign err_cnt = err_cnt_q;
`else
   assign chk_err = 1'b0;
   assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_share_arbiter
// Purpose  : Self-checking bench for inv_share_arbiter with a behavioural
//            inverter and a scoreboard of expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_share_arbiter;

   localparam int NREQ   = 4;
   localparam int W      = 4;
   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  gnt;
   logic [3:0]  inv_in;
   logic [3:0]  inv_out;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_data;
   logic        busy;
   logic        chk_err;
   logic [7:0]  err_cnt;

   logic [3:0]  op [4];
   logic        bad;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int       id;
      logic [3:0] data;
      bit       bad;
      int       cyc;
   } exp_t;

   exp_t q[$];
   exp_t it;

   int         cyc          = 0;
   int         m_ptr        = 0;
   int         exp_err      = 0;
   int         gnt_count    = 0;
   int         last_gnt_id  = -1;
   int         prev_gnt_cyc = -100;
   int         gnt_gap      = 0;
   int         e_id;
   int         gnt_id_cnt [4] = '{default: 0};
   logic [3:0] req_s;

   inv_share_arbiter #(
      .NREQ   (NREQ),
      .W      (W),
      .SETTLE (SETTLE)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .inv_in    (inv_in),
      .inv_out   (inv_out),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .chk_err   (chk_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Operand bus and inverter model (bad = corrupted, non-inverting output).
   always_comb req_data = {op[3], op[2], op[1], op[0]};
   always_comb inv_out  = bad ? inv_in : ~inv_in;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   // Monitor: push expectations at grant, pop and compare at response.
   always @(posedge clk) begin
      req_s = req;
      cyc++;
      #1;
      if (rst) begin
         q.delete();
         m_ptr        = 0;
         exp_err      = 0;
         prev_gnt_cyc = -100;
      end else begin
         if (gnt != 4'b0) begin
            e_id = exp_pick(req_s, m_ptr);
            if (e_id < 0) begin
               check_eq("gnt_spurious", 32'(gnt), 32'd0);
            end else begin
               check_eq("gnt", 32'(gnt), 32'd1 << e_id);
               check_eq("inv_in", 32'(inv_in), 32'(op[e_id]));
               q.push_back('{id: e_id, data: (bad ? op[e_id] : ~op[e_id]), bad: bad, cyc: cyc});
               gnt_gap      = cyc - prev_gnt_cyc;
               prev_gnt_cyc = cyc;
               last_gnt_id  = e_id;
               gnt_id_cnt[e_id]++;
               gnt_count++;
            end
         end
         if (rsp_valid) begin
            if (q.size() == 0) begin
               check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               it = q.pop_front();
               check_eq("rsp_id", 32'(rsp_id), 32'(it.id));
               check_eq("rsp_data", 32'(rsp_data), 32'(it.data));
               check_eq("rsp_latency", 32'(cyc - it.cyc), 32'(SETTLE));
`ifdef INV_ARB_CHECK_EN
               if (it.bad && exp_err < 255) exp_err++;
               check_eq("chk_err", 32'(chk_err), 32'(it.bad));
`else
               check_eq("chk_err", 32'(chk_err), 32'd0);
`endif
               check_eq("err_cnt", 32'(err_cnt), 32'(exp_err));
               m_ptr = (it.id + 1) % 4;
            end
         end else begin
            check_eq("chk_err_idle", 32'(chk_err), 32'd0);
         end
      end
   end

   // Wait for n grants; optionally drop each granted request and check spacing.
   task automatic wait_grants(input int n, input bit hold, input bit chk_gap);
      int target;
      int seen;
      int budget;
      bit first;
      target = gnt_count + n;
      seen   = gnt_count;
      budget = n * 20 + 20;
      first  = 1'b1;
      while (gnt_count < target && budget > 0) begin
         @(negedge clk);
         budget--;
         if (gnt_count != seen) begin
            seen = gnt_count;
            if (!hold) req[last_gnt_id] = 1'b0;
            if (chk_gap && !first) check_eq("gnt_period", 32'(gnt_gap), 32'(SETTLE + 2));
            first = 1'b0;
            op[last_gnt_id] = 4'($urandom);
         end
      end
      if (gnt_count < target) check_eq("grant_timeout", 32'(gnt_count), 32'(target));
   endtask

   task automatic wait_idle();
      int budget;
      budget = 40;
      do begin
         @(negedge clk);
         budget--;
      end while ((busy || q.size() != 0) && budget > 0);
      if (busy || q.size() != 0) check_eq("idle_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_gnt"},       32'(gnt),       32'd0);
      check_eq({tag, "_inv_in"},    32'(inv_in),    32'd0);
      check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
      check_eq({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
      check_eq({tag, "_busy"},      32'(busy),      32'd0);
      check_eq({tag, "_chk_err"},   32'(chk_err),   32'd0);
      check_eq({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
   endtask

   // Directed stimulus sequence.
   initial begin
      int c2;
      rst = 1'b1;
      req = 4'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) op[i] = 4'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single request from requester 1.
      op[1] = 4'b0011;
      req   = 4'b0010;
      wait_grants(1, 1'b0, 1'b0);
      check_eq("busy_hi", 32'(busy), 32'd1);
      wait_idle();
      repeat (2) @(negedge clk);
      check_eq("rsp_data_hold", 32'(rsp_data), 32'hC);
      check_eq("rsp_id_hold", 32'(rsp_id), 32'd1);

      // All four held: five back-to-back rotating grants.
      for (int i = 0; i < 4; i++) op[i] = 4'($urandom);
      req = 4'b1111;
      wait_grants(5, 1'b1, 1'b1);
      req = 4'b0;
      wait_idle();

      // Boundary operands from requesters 2 and 3.
      op[2] = 4'b0000;
      op[3] = 4'b1111;
      req   = 4'b1100;
      wait_grants(2, 1'b0, 1'b0);
      wait_idle();

      // Corrupted inverter output, long enough to saturate the error count.
      bad = 1'b1;
      req = 4'b0001;
      wait_grants(300, 1'b1, 1'b0);
      req = 4'b0;
      wait_idle();
      bad = 1'b0;
`ifdef INV_ARB_CHECK_EN
      check_eq("err_sat", 32'(err_cnt), 32'd255);
`else
      check_eq("err_sat", 32'(err_cnt), 32'd0);
`endif

      // Reset during SETTLE: response dropped, pointer back to 0.
      req = 4'b0100;
      wait_grants(1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_vals("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      req = 4'b1001;
      wait_grants(1, 1'b0, 1'b0);
      check_eq("post_rst_gnt", 32'(last_gnt_id), 32'd0);
      wait_grants(1, 1'b0, 1'b0);
      wait_idle();

      // One-cycle pulse on req[2] while busy is never granted.
      req = 4'b0001;
      wait_grants(1, 1'b0, 1'b0);
      c2 = gnt_id_cnt[2];
      req[2] = 1'b1;
      @(negedge clk);
      req[2] = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      check_eq("lost_req", 32'(gnt_id_cnt[2]), 32'(c2));
      check_eq("final_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
